// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and default operand width for the shift-add multiplier
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mult_add_n.sv
// rtl/shift_add_mult_add_n.sv - combinational WIDTH-bit adder with carry-in and carry-out
module add_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - iterative unsigned shift-add multiplier; ZERO_SKIP_EN shortcuts zero operands
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  // Counter is sized to hold WIDTH itself so it never wraps within one operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     add_s;
  logic                 add_co;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   acc_shifted;

  add_n #(.WIDTH(WIDTH)) u_add (
    .x  (hi_q),
    .y  (mcand_q),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  // Partial-product step: add the multiplicand only when the current multiplier bit is set,
  // then drop the consumed multiplier bit by shifting {carry, sum, lo} right by one.
  always_comb begin
    carry       = 1'b0;
    sum         = hi_q;
    if (lo_q[0]) begin
      carry = add_co;
      sum   = add_s;
    end
    acc_shifted = {carry, sum, lo_q[WIDTH-1:1]};
  end

  // Next-state logic; p is only updated on entry to DONE so it holds the last product.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = CALC;
`ifdef ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            state_d = DONE;
            p_d     = '0;
          end
`endif
        end
      end
      CALC: begin
        {hi_d, lo_d} = acc_shifted;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          p_d     = acc_shifted;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything, including an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed and exhaustive scoreboard bench for shift_add_mult
module tb_shift_add_mult;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat;
    lat = W + 1;
`ifdef ZERO_SKIP_EN
    if ((av == '0) || (bv == '0)) lat = 1;
`endif
    return lat;
  endfunction

  // Pops the scoreboard and compares p when done is seen.
  task automatic score(input string tag);
    logic [2*W-1:0] e;
    if (sb_q.size() == 0) begin
      check({tag, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " p"}, 32'(p), 32'(e));
    end
  endtask

  // One start pulse, then wait for done with a bound and check latency, busy span, pulse width.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    int n;
    int busy_n;
    logic [2*W-1:0] e;
    e = 8'(av) * 8'(bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      n++;
    end
    if (busy) busy_n++;
    check({tag, " done_seen"}, 32'(done), 32'd1);
    if (done) begin
      check({tag, " latency"}, 32'(n), 32'(exp_latency(av, bv)));
      check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_latency(av, bv)));
      score(tag);
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(done), 32'd0);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      check({tag, " p_held"}, 32'(p), 32'(e));
    end else if (sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int n;
    int m;
    int dones;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset p", 32'(p), 32'd0);
    rst = 1'b0;

    run_op(4'd15, 4'd15, "max15x15");
    run_op(4'd3, 4'd5, "3x5");
    run_op(4'd1, 4'd1, "1x1");

    // Second start during CALC must be ignored.
    @(negedge clk);
    a = 4'd7;
    b = 4'd9;
    start = 1'b1;
    sb_q.push_back(8'd63);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd2;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ignore done_seen", 32'(done), 32'd1);
    check("ignore latency", 32'(n), 32'(W + 1));
    score("ignore");
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignore extra_done", 32'(dones), 32'd0);
    check("ignore p_held", 32'(p), 32'd63);

    run_op(4'd12, 4'd0, "12x0");

    // Reset in the second CALC cycle aborts with no done and p cleared.
    @(negedge clk);
    a = 4'd6;
    b = 4'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort p", 32'(p), 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    check("abort p_stays0", 32'(p), 32'd0);
    run_op(4'd6, 4'd6, "6x6_after_abort");

    // Start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    a = 4'd2;
    b = 4'd3;
    start = 1'b1;
    sb_q.push_back(8'd6);
    sb_q.push_back(8'd6);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b first_done", 32'(done), 32'd1);
    score("b2b first");
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!done && m < 20);
    start = 1'b0;
    check("b2b period", 32'(m), 32'(W + 2));
    score("b2b second");
    @(negedge clk);
    @(negedge clk);
    check("b2b stopped", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(W'(i), W'(j), $sformatf("sweep %0dx%0d", i, j));
      end
    end

    check("sb drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
